// File: rtl/lcm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcm_ctrl
//  Description : Least-common-multiple controller. Obtains GCD(A,B) from an
//                external GCD unit over a start/done/error handshake, then
//                computes (A / GCD) * B with a restoring subtract divider and
//                a shift-add multiplier. It offers the same handshake upstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcm_ctrl #(
    parameter int W       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   A_in,
    input  logic [W-1:0]   B_in,
    output logic           done,
    output logic [2*W-1:0] LCM,
    output logic           error,
    output logic           gcd_start,
    output logic [W-1:0]   gcd_a,
    output logic [W-1:0]   gcd_b,
    input  logic           gcd_done,
    input  logic [W-1:0]   gcd_result,
    input  logic           gcd_error
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam int             IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [2*W-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RELEASE = 3'd2,
        S_DIV     = 3'd3,
        S_MUL     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    g_q;
    logic [W-1:0]    r_q;
    logic [W-1:0]    quo_q;
    logic [2*W-1:0]  acc_q;
    logic [IW-1:0]   bit_q;
    logic [CW-1:0]   cnt_q;

    logic [CW-1:0]   cnt_d;
    logic [W-1:0]    r_d;
    logic [W-1:0]    quo_d;
    logic [2*W-1:0]  acc_d;
    logic            timeout_d;

    // Datapath next values: timeout count, divider step and multiplier step.
    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        timeout_d = (cnt_d == CW'(TIMEOUT));
        r_d       = r_q - g_q;
        quo_d     = quo_q + 1'b1;
        acc_d     = acc_q;
        if (quo_q[bit_q]) begin
            acc_d = acc_q + ({{W{1'b0}}, b_q} << bit_q);
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            g_q       <= '0;
            r_q       <= '0;
            quo_q     <= '0;
            acc_q     <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            LCM       <= '0;
            gcd_start <= 1'b0;
            gcd_a     <= '0;
            gcd_b     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (start) begin
                        a_q <= A_in;
                        b_q <= B_in;
                        if ((A_in == '0) && (B_in == '0)) begin
                            error   <= 1'b1;
                            LCM     <= ALL_ONES;
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end else if ((A_in == '0) || (B_in == '0)) begin
                            LCM     <= '0;
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end else if (!gcd_done) begin
                            // Never raise a request while the GCD unit is
                            // still showing a previous completion.
                            gcd_a     <= A_in;
                            gcd_b     <= B_in;
                            gcd_start <= 1'b1;
                            cnt_q     <= '0;
                            state_q   <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    if (gcd_done) begin
                        g_q       <= gcd_result;
                        gcd_start <= 1'b0;
                        if (gcd_error || (gcd_result == '0)) begin
                            error   <= 1'b1;
                            LCM     <= ALL_ONES;
                            done    <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else if (timeout_d) begin
                        gcd_start <= 1'b0;
                        error     <= 1'b1;
                        LCM       <= ALL_ONES;
                        done      <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_RELEASE: begin
                    if (!gcd_done) begin
                        r_q     <= a_q;
                        quo_q   <= '0;
                        state_q <= S_DIV;
                    end else if (timeout_d) begin
                        error   <= 1'b1;
                        LCM     <= ALL_ONES;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_DIV: begin
                    // GCD divides A exactly, so the remainder ends at zero.
                    if (r_q >= g_q) begin
                        r_q   <= r_d;
                        quo_q <= quo_d;
                    end else begin
                        acc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_MUL;
                    end
                end

                S_MUL: begin
                    acc_q <= acc_d;
                    if (bit_q == IW'(W - 1)) begin
                        LCM     <= acc_d;
                        done    <= 1'b1;
                        error   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        bit_q <= bit_q + 1'b1;
                    end
                end

                S_DONE: begin
                    // Result is held until the requester drops start.
                    if (!start) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
